// File: rtl/motorpasso_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// motorpasso_ocimem_arbiter
//
// Shares the Nios II on-chip debug monitor register/memory port between two
// requesters in the sysclk domain:
//   requester 0 - JTAG debug-slave path (decoded jdo commands)
//   requester 1 - local host bridge (cable-less debug access)
//
// Round-robin grant on ties, one access strobe per transaction, bounded wait
// for monitor_ready, and read data/status returned to the granted requester.
//
// Ports:
//   clk, reset_n               system clock, asynchronous active-low reset
//   rN_req                     request level, held until rN_done
//   rN_write/addr/wdata        access description, sampled at grant
//   rN_gnt                     one-cycle accept pulse
//   rN_done                    one-cycle completion pulse
//   rN_rdata/rN_err            result, valid with done, held until next done
//   ocimem_addr/ocimem_wdata   access address/data toward the monitor
//   ocimem_read/ocimem_write   one-cycle access strobes
//   MonDReg                    monitor read data
//   monitor_ready/error        access completion/failure from the monitor
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module motorpasso_ocimem_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16   // legal range 2..255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic [ADDR_W-1:0] ocimem_addr,
    output logic [DATA_W-1:0] ocimem_wdata,
    output logic              ocimem_read,
    output logic              ocimem_write,
    input  logic [DATA_W-1:0] MonDReg,
    input  logic              monitor_ready,
    input  logic              monitor_error
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                write_q, write_d;
    logic                last_q, last_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                err0_q, err0_d, err1_q, err1_d;

    // Completion result computed in WAIT, steered to the granted requester.
    logic                fin;
    logic [DATA_W-1:0]   fin_rdata;
    logic                fin_err;
    logic                pick;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        write_d   = write_q;
        last_d    = last_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        fin       = 1'b0;
        fin_rdata = '0;
        fin_err   = 1'b0;
        pick      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    // Tie goes to the requester that was not served last.
                    pick    = (r0_req && r1_req) ? ~last_q : r1_req;
                    state_d = S_ISSUE;
                    sel_d   = pick;
                    last_d  = pick;
                    write_d = pick ? r1_write : r0_write;
                    addr_d  = pick ? r1_addr  : r0_addr;
                    wdata_d = pick ? r1_wdata : r0_wdata;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    rd_d    = ~write_d;
                    wr_d    = write_d;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (monitor_ready) begin
                    fin       = 1'b1;
                    fin_err   = monitor_error;
                    fin_rdata = (write_q || monitor_error) ? '0 : MonDReg;
                end else if (timer_q == TIMER_LAST) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (fin) begin
                    state_d = S_DONE;
                    if (sel_q) begin
                        done1_d  = 1'b1;
                        rdata1_d = fin_rdata;
                        err1_d   = fin_err;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = fin_rdata;
                        err0_d   = fin_err;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            write_q  <= 1'b0;
            last_q   <= 1'b1;
            timer_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            write_q  <= write_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    assign r0_gnt       = gnt0_q;
    assign r1_gnt       = gnt1_q;
    assign r0_done      = done0_q;
    assign r1_done      = done1_q;
    assign r0_rdata     = rdata0_q;
    assign r1_rdata     = rdata1_q;
    assign r0_err       = err0_q;
    assign r1_err       = err1_q;
    assign ocimem_addr  = addr_q;
    assign ocimem_wdata = wdata_q;
    assign ocimem_read  = rd_q;
    assign ocimem_write = wr_q;

endmodule

// File: tb/tb_motorpasso_ocimem_arbiter.sv
module tb_motorpasso_ocimem_arbiter;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              r0_req, r0_write, r1_req, r1_write;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic              r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic [ADDR_W-1:0] ocimem_addr;
    logic [DATA_W-1:0] ocimem_wdata;
    logic              ocimem_read, ocimem_write;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready, monitor_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    motorpasso_ocimem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .r0_req       (r0_req),
        .r0_write     (r0_write),
        .r0_addr      (r0_addr),
        .r0_wdata     (r0_wdata),
        .r0_gnt       (r0_gnt),
        .r0_done      (r0_done),
        .r0_rdata     (r0_rdata),
        .r0_err       (r0_err),
        .r1_req       (r1_req),
        .r1_write     (r1_write),
        .r1_addr      (r1_addr),
        .r1_wdata     (r1_wdata),
        .r1_gnt       (r1_gnt),
        .r1_done      (r1_done),
        .r1_rdata     (r1_rdata),
        .r1_err       (r1_err),
        .ocimem_addr  (ocimem_addr),
        .ocimem_wdata (ocimem_wdata),
        .ocimem_read  (ocimem_read),
        .ocimem_write (ocimem_write),
        .MonDReg      (MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        r0_req = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        MonDReg = '0; monitor_ready = 1'b0; monitor_error = 1'b0;

        // ---- reset values ----
        tick(); tick();
        chk("rst_pulses", {26'd0, r0_gnt, r1_gnt, r0_done, r1_done, ocimem_read, ocimem_write}, 32'd0);
        chk("rst_err", {30'd0, r0_err, r1_err}, 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'd0);
        chk("rst_r1_rdata", r1_rdata, 32'd0);
        chk("rst_oci_addr", {23'd0, ocimem_addr}, 32'd0);
        chk("rst_oci_wdata", ocimem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // ---- tie after reset: r0 first, then r1 ----
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 9'h010;
        r1_req = 1'b1; r1_write = 1'b0; r1_addr = 9'h020;
        tick();
        chk("tie1_gnt_r0", {30'd0, r0_gnt, r1_gnt}, 32'h2);
        chk("tie1_addr_r0", {23'd0, ocimem_addr}, 32'h010);
        chk("tie1_strobe_r0", {30'd0, ocimem_read, ocimem_write}, 32'h2);
        tick();
        chk("tie1_gnt_drop", {30'd0, r0_gnt, r1_gnt}, 32'h0);
        monitor_ready = 1'b1; MonDReg = 32'hAAAA0000;
        tick();
        chk("tie1_done_r0", {30'd0, r0_done, r1_done}, 32'h2);
        chk("tie1_rdata_r0", r0_rdata, 32'hAAAA0000);
        chk("tie1_err_r0", {31'd0, r0_err}, 32'h0);
        monitor_ready = 1'b0; r0_req = 1'b0;
        tick();
        chk("tie1_idle_gap", {30'd0, r0_gnt, r1_gnt}, 32'h0);
        tick();
        chk("tie1_gnt_r1", {30'd0, r0_gnt, r1_gnt}, 32'h1);
        chk("tie1_addr_r1", {23'd0, ocimem_addr}, 32'h020);
        tick();
        monitor_ready = 1'b1; MonDReg = 32'h00005555;
        tick();
        chk("tie1_done_r1", {30'd0, r0_done, r1_done}, 32'h1);
        chk("tie1_rdata_r1", r1_rdata, 32'h00005555);
        chk("tie1_r0_hold", r0_rdata, 32'hAAAA0000);
        monitor_ready = 1'b0; r1_req = 1'b0;
        tick();

        // ---- single r0 read with minimum latency ----
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 9'h100; MonDReg = '0;
        tick();
        chk("rd_gnt", {31'd0, r0_gnt}, 32'h1);
        chk("rd_strobe", {30'd0, ocimem_read, ocimem_write}, 32'h2);
        chk("rd_addr", {23'd0, ocimem_addr}, 32'h100);
        tick();
        chk("rd_strobe_1cyc", {30'd0, ocimem_read, ocimem_write}, 32'h0);
        chk("rd_no_early_done", {31'd0, r0_done}, 32'h0);
        monitor_ready = 1'b1; MonDReg = 32'hDEADBEEF;
        tick();
        chk("rd_done", {31'd0, r0_done}, 32'h1);
        chk("rd_rdata", r0_rdata, 32'hDEADBEEF);
        chk("rd_err", {31'd0, r0_err}, 32'h0);
        monitor_ready = 1'b0; r0_req = 1'b0; MonDReg = '0;
        tick();
        chk("rd_done_1cyc", {31'd0, r0_done}, 32'h0);

        // ---- tie with last_grant=r0: r1 write first, then r0 read with error ----
        r1_req = 1'b1; r1_write = 1'b1; r1_addr = 9'h005; r1_wdata = 32'h12345678;
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 9'h0F0;
        tick();
        chk("tie2_gnt_r1", {30'd0, r0_gnt, r1_gnt}, 32'h1);
        chk("wr_strobe", {30'd0, ocimem_read, ocimem_write}, 32'h1);
        chk("wr_addr", {23'd0, ocimem_addr}, 32'h005);
        chk("wr_wdata", ocimem_wdata, 32'h12345678);
        tick();
        chk("wr_no_strobe", {30'd0, ocimem_read, ocimem_write}, 32'h0);
        monitor_ready = 1'b1; MonDReg = 32'hFFFFFFFF;
        tick();
        chk("wr_done", {30'd0, r0_done, r1_done}, 32'h1);
        chk("wr_rdata_zero", r1_rdata, 32'h0);
        chk("wr_err", {31'd0, r1_err}, 32'h0);
        monitor_ready = 1'b0; r1_req = 1'b0; r1_write = 1'b0;
        tick();
        tick();
        chk("tie2_gnt_r0", {30'd0, r0_gnt, r1_gnt}, 32'h2);
        chk("tie2_rd_strobe", {30'd0, ocimem_read, ocimem_write}, 32'h2);
        chk("tie2_addr_r0", {23'd0, ocimem_addr}, 32'h0F0);
        tick();
        monitor_ready = 1'b1; monitor_error = 1'b1; MonDReg = 32'h13579BDF;
        tick();
        chk("merr_done", {31'd0, r0_done}, 32'h1);
        chk("merr_err", {31'd0, r0_err}, 32'h1);
        chk("merr_rdata_zero", r0_rdata, 32'h0);
        monitor_ready = 1'b0; monitor_error = 1'b0; r0_req = 1'b0;
        tick();

        // ---- timeout: no ready, done TIMEOUT+1 cycles after gnt ----
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 9'h0AA;
        tick();
        chk("to_gnt", {31'd0, r0_gnt}, 32'h1);
        repeat (TIMEOUT) tick();
        chk("to_not_early", {31'd0, r0_done}, 32'h0);
        tick();
        chk("to_done", {31'd0, r0_done}, 32'h1);
        chk("to_err", {31'd0, r0_err}, 32'h1);
        chk("to_rdata_zero", r0_rdata, 32'h0);
        r0_req = 1'b0;
        tick();

        // ---- ready on the last WAIT cycle wins over timeout ----
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 9'h0AB;
        tick();
        chk("tol_gnt", {31'd0, r0_gnt}, 32'h1);
        repeat (TIMEOUT) tick();
        chk("tol_not_early", {31'd0, r0_done}, 32'h0);
        monitor_ready = 1'b1; monitor_error = 1'b0; MonDReg = 32'hCAFEF00D;
        tick();
        chk("tol_done", {31'd0, r0_done}, 32'h1);
        chk("tol_err", {31'd0, r0_err}, 32'h0);
        chk("tol_rdata", r0_rdata, 32'hCAFEF00D);
        monitor_ready = 1'b0; r0_req = 1'b0;
        tick();

        // ---- spurious ready in IDLE ----
        monitor_ready = 1'b1; monitor_error = 1'b1; MonDReg = 32'h11111111;
        tick();
        chk("spur_quiet_a", {26'd0, r0_gnt, r1_gnt, r0_done, r1_done, ocimem_read, ocimem_write}, 32'd0);
        tick();
        chk("spur_quiet_b", {26'd0, r0_gnt, r1_gnt, r0_done, r1_done, ocimem_read, ocimem_write}, 32'd0);
        chk("spur_r0_hold", r0_rdata, 32'hCAFEF00D);
        chk("spur_err_hold", {31'd0, r0_err}, 32'h0);
        monitor_ready = 1'b0; monitor_error = 1'b0;
        tick();

        // ---- reset during WAIT, then held r1_req re-arbitrated ----
        r1_req = 1'b1; r1_write = 1'b0; r1_addr = 9'h033;
        tick();
        chk("rw_gnt", {31'd0, r1_gnt}, 32'h1);
        chk("rw_strobe", {30'd0, ocimem_read, ocimem_write}, 32'h2);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rw_rst_pulses", {26'd0, r0_gnt, r1_gnt, r0_done, r1_done, ocimem_read, ocimem_write}, 32'd0);
        chk("rw_rst_r0_rdata", r0_rdata, 32'h0);
        chk("rw_rst_r1_rdata", r1_rdata, 32'h0);
        chk("rw_rst_addr", {23'd0, ocimem_addr}, 32'h0);
        tick();
        chk("rw_no_done", {30'd0, r0_done, r1_done}, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rw_regnt", {30'd0, r0_gnt, r1_gnt}, 32'h1);
        chk("rw_readdr", {23'd0, ocimem_addr}, 32'h033);
        tick();
        monitor_ready = 1'b1; MonDReg = 32'h0BADC0DE;
        tick();
        chk("rw_done", {30'd0, r0_done, r1_done}, 32'h1);
        chk("rw_rdata", r1_rdata, 32'h0BADC0DE);
        chk("rw_err", {31'd0, r1_err}, 32'h0);
        monitor_ready = 1'b0; r1_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
